// File: rtl/dll_delay_ctrl.sv
// Delay-line control for the FMDLL loop: SAR search of Q, then +/-1 tracking
// with lock declared after sustained dithering about the optimum code.
module dll_delay_ctrl #(
   parameter int QW       = 10,
   parameter int LOCK_CNT = 4,
   parameter int CW       = 3
) (
   input  logic          clk_ext,
   input  logic          Reset_n,
   input  logic          enable,
   input  logic          start,
   input  logic          COMP,
   input  logic [1:0]    M_counter,
   input  logic [3:0]    N_counter,
   input  logic [1:0]    M,
   input  logic [3:0]    N,
   output logic [QW-1:0] Q,
   output logic [QW-1:0] Q_next,
   output logic          update,
   output logic          sar_done,
   output logic          lock,
   output logic          busy
);

   localparam int IW = (QW > 1) ? $clog2(QW) : 1;
   localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CNT);
   localparam logic [IW-1:0] IDX_TOP  = IW'(QW - 1);

   typedef enum logic [1:0] {IDLE, SAR, TRACK, LOCKED} state_t;

   state_t        state, state_nx;
   logic [QW-1:0] q_d, q_sar, q_trk;
   logic [IW-1:0] idx, idx_nx;
   logic [CW-1:0] rev_cnt, run_cnt, rev_nx, run_nx;
   logic          dir_prev, dir_prev_nx, dir_vld, dir_vld_nx;
   logic          sar_done_nx, lock_nx, load;
   logic          win, win_d, strobe;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= LOCK_MAX) ? v : v + CW'(1);
   endfunction

   assign win    = (M_counter == M) && (N_counter == N);
   assign strobe = win & ~win_d;
   assign busy   = (state != IDLE);

   // Candidate codes for the current COMP; shared by the preview and the update.
   always_comb begin
      q_sar = Q;
      if (!COMP) q_sar[idx] = 1'b0;
      if (idx != '0) q_sar[idx - IW'(1)] = 1'b1;
      if (COMP) q_trk = (&Q) ? Q : Q + QW'(1);
      else      q_trk = (|Q) ? Q - QW'(1) : Q;
      case (state)
         SAR:          Q_next = q_sar;
         TRACK, LOCKED: Q_next = q_trk;
         default:      Q_next = Q;
      endcase
   end

   always_comb begin
      state_nx    = state;
      q_d         = Q;
      idx_nx      = idx;
      rev_nx      = rev_cnt;
      run_nx      = run_cnt;
      dir_prev_nx = dir_prev;
      dir_vld_nx  = dir_vld;
      sar_done_nx = sar_done;
      lock_nx     = lock;
      load        = 1'b0;
      if (!enable) begin
         state_nx    = IDLE;
         lock_nx     = 1'b0;
         sar_done_nx = 1'b0;
         rev_nx      = '0;
         run_nx      = '0;
         dir_vld_nx  = 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               q_d         = {1'b1, {(QW-1){1'b0}}};
               idx_nx      = IDX_TOP;
               sar_done_nx = 1'b0;
               load        = 1'b1;
               state_nx    = SAR;
            end
            SAR: if (strobe) begin
               q_d = q_sar;
               if (idx != '0) idx_nx = idx - IW'(1);
               else begin
                  state_nx    = TRACK;
                  sar_done_nx = 1'b1;
                  rev_nx      = '0;
                  run_nx      = '0;
                  dir_vld_nx  = 1'b0;
               end
            end
            default: if (strobe) begin
               q_d         = q_trk;
               dir_prev_nx = COMP;
               dir_vld_nx  = 1'b1;
               // The first tracking strobe only seeds dir_prev.
               if (dir_vld) begin
                  if (COMP != dir_prev) begin
                     rev_nx = sat_inc(rev_cnt);
                     run_nx = '0;
                  end else begin
                     run_nx = sat_inc(run_cnt);
                     rev_nx = '0;
                  end
               end
               if (state == TRACK && rev_nx >= LOCK_MAX) begin
                  state_nx = LOCKED;
                  lock_nx  = 1'b1;
               end else if (state == LOCKED && run_nx >= LOCK_MAX) begin
                  state_nx = TRACK;
                  lock_nx  = 1'b0;
                  rev_nx   = '0;
                  run_nx   = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_ext or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         Q        <= '0;
         idx      <= IDX_TOP;
         rev_cnt  <= '0;
         run_cnt  <= '0;
         dir_prev <= 1'b0;
         dir_vld  <= 1'b0;
         sar_done <= 1'b0;
         lock     <= 1'b0;
         update   <= 1'b0;
         win_d    <= 1'b0;
      end else begin
         state    <= state_nx;
         Q        <= q_d;
         idx      <= idx_nx;
         rev_cnt  <= rev_nx;
         run_cnt  <= run_nx;
         dir_prev <= dir_prev_nx;
         dir_vld  <= dir_vld_nx;
         sar_done <= sar_done_nx;
         lock     <= lock_nx;
         update   <= load | (q_d != Q);
         win_d    <= win;
      end
   end

endmodule

// File: tb/tb_dll_delay_ctrl.sv
// Self-checking bench for dll_delay_ctrl against an arithmetic reference model.
`timescale 1ns/100ps
module tb_dll_delay_ctrl;

   localparam int QW       = 10;
   localparam int LOCK_CNT = 4;
   localparam int CW       = 3;
   localparam int QMAX     = (1 << QW) - 1;

   logic          clk_ext = 1'b0, Reset_n = 1'b0, enable = 1'b0, start = 1'b0, COMP = 1'b0;
   logic [1:0]    M_counter = '0, M = 2'd2;
   logic [3:0]    N_counter = '0, N = 4'd9;
   logic [QW-1:0] Q, Q_next;
   logic          update, sar_done, lock, busy;

   int checks = 0, failures = 0;
   int upd_obs = 0, upd_exp = 0;

   // Reference model: mode 0 idle, 1 search, 2 tracking, 3 locked.
   int m_mode, m_q, m_step;
   bit m_sar_done, m_lock, m_upd, m_winp;
   bit hist[$];

   always #5 clk_ext = ~clk_ext;

   dll_delay_ctrl #(.QW(QW), .LOCK_CNT(LOCK_CNT), .CW(CW)) dut (
      .clk_ext(clk_ext), .Reset_n(Reset_n), .enable(enable), .start(start), .COMP(COMP),
      .M_counter(M_counter), .N_counter(N_counter), .M(M), .N(N),
      .Q(Q), .Q_next(Q_next), .update(update), .sar_done(sar_done), .lock(lock), .busy(busy)
   );

   function automatic void model_reset();
      m_mode = 0; m_q = 0; m_step = 0;
      m_sar_done = 0; m_lock = 0; m_upd = 0; m_winp = 0;
      hist.delete();
   endfunction

   function automatic int preview(bit comp);
      int nq;
      case (m_mode)
         1: begin
            nq = comp ? m_q : m_q - m_step;
            if (m_step > 1) nq += m_step / 2;
         end
         2, 3: nq = comp ? ((m_q < QMAX) ? m_q + 1 : m_q) : ((m_q > 0) ? m_q - 1 : 0);
         default: nq = m_q;
      endcase
      return nq;
   endfunction

   function automatic void model_edge(bit en, bit st, bit comp, bit win);
      bit strb, last;
      int nq, rev, run;
      strb = win && !m_winp;
      m_winp = win;
      m_upd = 0;
      if (!en) begin
         m_mode = 0; m_lock = 0; m_sar_done = 0;
      end else if (m_mode == 0) begin
         if (st) begin
            m_q = 1 << (QW - 1); m_step = m_q; m_mode = 1; m_sar_done = 0; m_upd = 1;
         end
      end else if (strb) begin
         nq = preview(comp);
         m_upd = (nq != m_q);
         if (m_mode == 1) begin
            if (m_step > 1) m_step /= 2;
            else begin m_mode = 2; m_sar_done = 1; hist.delete(); end
         end else begin
            hist.push_back(comp);
            if (hist.size() > 16) void'(hist.pop_front());
            rev = 0; run = 0;
            for (int k = hist.size() - 1; k > 0; k--) if (hist[k] != hist[k-1]) rev++; else break;
            for (int k = hist.size() - 1; k > 0; k--) if (hist[k] == hist[k-1]) run++; else break;
            if (m_mode == 2 && rev >= LOCK_CNT) begin
               m_mode = 3; m_lock = 1;
            end else if (m_mode == 3 && run >= LOCK_CNT) begin
               m_mode = 2; m_lock = 0;
               last = hist[hist.size() - 1];
               hist.delete();
               hist.push_back(last);
            end
         end
         m_q = nq;
      end
   endfunction

   function automatic logic [QW+3:0] exp_vec();
      return {QW'(m_q), m_upd, m_lock, m_sar_done, (m_mode != 0)};
   endfunction

   task automatic step(input bit en, input bit st, input bit comp, input bit win);
      enable = en; start = st; COMP = comp;
      M_counter = M;
      N_counter = win ? N : (N ^ 4'd1);
      @(posedge clk_ext);
      model_edge(en, st, comp, win);
      #1;
      upd_obs += int'(update);
      upd_exp += int'(m_upd);
   endtask

   task automatic strobe(input bit comp);
      step(1'b1, 1'b0, comp, 1'b0);
      step(1'b1, 1'b0, comp, 1'b1);
   endtask

   task automatic begin_search();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      upd_obs = int'(update); upd_exp = int'(m_upd);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      repeat (2) @(posedge clk_ext);
      #1;
      model_reset();
      if ({Q, update, lock, sar_done, busy} !== exp_vec()) begin
         failures++; $display("FAIL reset_state: got %h exp %h", {Q, update, lock, sar_done, busy}, exp_vec());
      end
      checks++;
      Reset_n = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      if ({Q, update, lock, sar_done, busy, Q_next} !== {exp_vec(), QW'(preview(COMP))}) begin
         failures++; $display("FAIL reset_idle: got Q=%0d Q_next=%0d busy=%b", Q, Q_next, busy);
      end
      checks++;
   endtask

   task automatic test_sar(input bit comp, input string name, input int final_q);
      begin_search();
      if (Q !== QW'(512) || busy !== 1'b1) begin
         failures++; $display("FAIL %s_load: got Q=%0d busy=%b exp Q=512 busy=1", name, Q, busy);
      end
      checks++;
      for (int s = 0; s < QW; s++) begin
         strobe(comp);
         if ({Q, update, lock, sar_done, busy, Q_next} !== {exp_vec(), QW'(preview(COMP))}) begin
            failures++; $display("FAIL %s_strobe%0d: got %h/%0d exp %h/%0d", name, s,
                                 {Q, update, lock, sar_done, busy}, Q_next, exp_vec(), preview(COMP));
         end
         checks++;
      end
      step(1'b1, 1'b0, comp, 1'b0);
      if (Q !== QW'(final_q) || sar_done !== 1'b1 || upd_obs !== upd_exp) begin
         failures++; $display("FAIL %s_done: got Q=%0d done=%b upd=%0d exp Q=%0d done=1 upd=%0d",
                              name, Q, sar_done, upd_obs, final_q, upd_exp);
      end
      checks++;
   endtask

   task automatic test_lock();
      begin_search();
      for (int s = 0; s < QW; s++) strobe(m_q < 300);
      if (Q !== QW'(299) || sar_done !== 1'b1) begin
         failures++; $display("FAIL lock_sar: got Q=%0d done=%b exp Q=299 done=1", Q, sar_done);
      end
      checks++;
      for (int s = 0; s < 5; s++) begin
         strobe(s % 2 == 0);
         if ({Q, update, lock, sar_done, busy} !== exp_vec()) begin
            failures++; $display("FAIL lock_dither%0d: got %h exp %h", s, {Q, update, lock, sar_done, busy}, exp_vec());
         end
         checks++;
      end
      if (Q !== QW'(300) || lock !== 1'b1) begin
         failures++; $display("FAIL lock_acquire: got Q=%0d lock=%b exp Q=300 lock=1", Q, lock);
      end
      checks++;
      for (int s = 0; s < 5; s++) begin
         strobe(1'b0);
         if ({Q, update, lock, sar_done, busy} !== exp_vec()) begin
            failures++; $display("FAIL unlock_run%0d: got %h exp %h", s, {Q, update, lock, sar_done, busy}, exp_vec());
         end
         checks++;
      end
      if (Q !== QW'(295) || lock !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL unlock: got Q=%0d lock=%b busy=%b exp Q=295 lock=0 busy=1", Q, lock, busy);
      end
      checks++;
   endtask

   task automatic test_saturation(input bit comp, input int edge_q);
      begin_search();
      for (int s = 0; s < QW; s++) strobe(comp);
      upd_obs = 0; upd_exp = 0;
      for (int s = 0; s < 3; s++) strobe(comp);
      if (Q !== QW'(edge_q) || Q_next !== QW'(edge_q) || upd_obs !== 0 || upd_exp !== 0) begin
         failures++; $display("FAIL saturate_%0d: got Q=%0d Q_next=%0d upd=%0d exp Q=%0d upd=0",
                              edge_q, Q, Q_next, upd_obs, edge_q);
      end
      checks++;
   endtask

   task automatic test_async_reset();
      begin_search();
      for (int s = 0; s < 5; s++) strobe(1'($urandom_range(0, 1)));
      Reset_n = 1'b0;
      #0.5;
      model_reset();
      if ({Q, lock, busy, sar_done} !== {QW'(0), 3'b000}) begin
         failures++; $display("FAIL async_reset: got Q=%0d lock=%b busy=%b exp Q=0 lock=0 busy=0", Q, lock, busy);
      end
      checks++;
      #0.5;
      Reset_n = 1'b1;
   endtask

   task automatic test_start_on_strobe();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      if (Q !== QW'(512) || busy !== 1'b1) begin
         failures++; $display("FAIL start_on_strobe: got Q=%0d busy=%b exp Q=512 busy=1", Q, busy);
      end
      checks++;
      for (int s = 0; s < QW - 1; s++) strobe(1'($urandom_range(0, 1)));
      if (sar_done !== 1'b0 || {Q, update, lock, sar_done, busy} !== exp_vec()) begin
         failures++; $display("FAIL strobe_not_consumed: got %h exp %h", {Q, update, lock, sar_done, busy}, exp_vec());
      end
      checks++;
      strobe(1'($urandom_range(0, 1)));
      if (sar_done !== 1'b1 || {Q, update, lock, sar_done, busy} !== exp_vec()) begin
         failures++; $display("FAIL start_strobe_done: got %h exp %h", {Q, update, lock, sar_done, busy}, exp_vec());
      end
      checks++;
   endtask

   task automatic test_no_window();
      begin_search();
      N = 4'd15;
      for (int c = 0; c < 40; c++) begin
         enable = 1'b1; start = 1'b0; COMP = 1'($urandom_range(0, 1));
         M_counter = 2'(c % 4);
         N_counter = 4'(c % 15);
         @(posedge clk_ext);
         model_edge(1'b1, 1'b0, COMP, 1'b0);
         #1;
      end
      if (Q !== QW'(512) || busy !== 1'b1 || sar_done !== 1'b0 || Q_next !== QW'(preview(COMP))) begin
         failures++; $display("FAIL no_window: got Q=%0d busy=%b done=%b exp Q=512 busy=1 done=0", Q, busy, sar_done);
      end
      checks++;
      N = 4'd9;
   endtask

   task automatic test_random();
      int target;
      bit c;
      for (int r = 0; r < 4; r++) begin
         target = $urandom_range(0, QMAX);
         begin_search();
         for (int s = 0; s < QW; s++) strobe(m_q < target);
         if (Q !== QW'((target > 0) ? target - 1 : 0)) begin
            failures++; $display("FAIL rand_sar%0d: got Q=%0d exp %0d", r, Q, (target > 0) ? target - 1 : 0);
         end
         checks++;
         for (int s = 0; s < 30; s++) begin
            c = ($urandom_range(0, 7) == 0) ? 1'($urandom_range(0, 1)) : (m_q < target);
            repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, c, 1'b0);
            step(($urandom_range(0, 29) != 0), 1'b0, c, 1'b1);
            if ({Q, update, lock, sar_done, busy, Q_next} !== {exp_vec(), QW'(preview(COMP))}) begin
               failures++; $display("FAIL rand_track%0d_%0d: got %h/%0d exp %h/%0d", r, s,
                                    {Q, update, lock, sar_done, busy}, Q_next, exp_vec(), preview(COMP));
            end
            checks++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sar(1'b1, "sar_ones", 1023);
      test_sar(1'b0, "sar_zeros", 0);
      test_lock();
      test_saturation(1'b1, 1023);
      test_saturation(1'b0, 0);
      test_async_reset();
      test_start_on_strobe();
      test_no_window();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
